// File: rtl/cla_pkg.sv
// Shared symbol encodings and helpers for the CLA sum-resolve stage.
package cla_pkg;

  typedef logic [7:0] cla_sym_t;

  localparam cla_sym_t SYM_K = 8'h6B;
  localparam cla_sym_t SYM_P = 8'h70;
  localparam cla_sym_t SYM_G = 8'h67;

  function automatic logic is_legal_sym(input cla_sym_t s);
    return (s == SYM_K) || (s == SYM_P) || (s == SYM_G);
  endfunction

endpackage

// File: rtl/cla_sym_classify.sv
// Decodes one kpg symbol byte into generate / propagate / legal flags.
import cla_pkg::*;

module cla_sym_classify (
  input  logic [7:0] sym,
  output logic       is_g,
  output logic       is_p,
  output logic       legal
);

  assign is_g  = (sym == SYM_G);
  assign is_p  = (sym == SYM_P);
  assign legal = is_legal_sym(sym);

endmodule

// File: rtl/cla_sum_resolve.sv
// Final sum stage of the CLA: kpg/prefix vectors -> sum and carry-out, two-stage pipeline.
// Optional symbol fault checking is built when CLA_SYM_CHECK_EN is defined.
import cla_pkg::*;

module cla_sum_resolve #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(WIDTH+1)*8-1:0] x,
  input  logic [(WIDTH+1)*8-1:0] y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout,
  output logic                   sym_err
);

  logic [WIDTH:0]   x_g, x_p, x_l;
  logic [WIDTH:0]   y_g, y_p, y_l;
  logic [WIDTH-1:0] p_in, c_in;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cls
    cla_sym_classify u_x (
      .sym   (x[i*8 +: 8]),
      .is_g  (x_g[i]),
      .is_p  (x_p[i]),
      .legal (x_l[i])
    );
    cla_sym_classify u_y (
      .sym   (y[i*8 +: 8]),
      .is_g  (y_g[i]),
      .is_p  (y_p[i]),
      .legal (y_l[i])
    );
  end

  // Symbol i describes operand bit i-1; resolved y[i-1] is the carry into bit i-1.
  assign p_in = x_p[WIDTH:1];
  assign c_in = y_g[WIDTH-1:0];

  // Valid/ready: a transfer happens on any rising edge with valid && ready;
  // a stalled output (out_valid && !out_ready) keeps sum/cout/sym_err stable.
  logic             ready_en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_c;
  logic             s1_co;
  logic             s2_free;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = ready_en && (!s1_valid || s2_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_c      <= '0;
      s1_co     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_p  <= p_in;
        s1_c  <= c_in;
        s1_co <= y_g[WIDTH];
      end
      if (s2_free) out_valid <= s1_valid;
      if (s2_free && s1_valid) begin
        sum  <= s1_p ^ s1_c;
        cout <= s1_co;
      end
    end
  end

`ifdef CLA_SYM_CHECK_EN
  logic err_in;
  logic s1_err;
  logic unused_cls;

  // Unresolved carry, illegal byte anywhere, or a rewritten carry-in symbol.
  assign err_in     = (|y_p) | ~(&x_l) | ~(&y_l) | (y[7:0] != x[7:0]);
  assign unused_cls = ^{x_g, x_p[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err  <= 1'b0;
      sym_err <= 1'b0;
    end else begin
      if (in_ready && in_valid) s1_err <= err_in;
      if (s2_free && s1_valid) sym_err <= s1_err;
    end
  end
`else
  logic unused_cls;

  assign unused_cls = ^{x_g, x_p[0], x_l, y_p, y_l};
  assign sym_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cla_sum_resolve.sv
// Directed bench for cla_sum_resolve: latency, streaming, stall, reset and symbol faults.
module tb_cla_sum_resolve;

  localparam int W  = 32;
  localparam int XW = (W + 1) * 8;
  localparam logic [7:0] K = 8'h6B;
  localparam logic [7:0] P = 8'h70;
  localparam logic [7:0] G = 8'h67;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x, y;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          sym_err;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];  // {sym_err, cout, sum}

  cla_sum_resolve #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .sym_err   (sym_err)
  );

  always #5 clk = ~clk;

  // Reference prefix model: kpg per bit, carry-in symbol at index 0, ripple resolve.
  task automatic make_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [XW-1:0] xv, output logic [XW-1:0] yv);
    logic [7:0] s, prev;
    xv = '0;
    yv = '0;
    s = cin ? G : K;
    xv[7:0] = s;
    yv[7:0] = s;
    prev = s;
    for (int i = 1; i <= W; i++) begin
      if (a[i-1] && b[i-1])      s = G;
      else if (a[i-1] ^ b[i-1])  s = P;
      else                       s = K;
      xv[i*8 +: 8] = s;
      if (s != P) prev = s;
      yv[i*8 +: 8] = prev;
    end
  endtask

  // Applies inputs after the falling edge and samples everything 1 time unit later.
  task automatic drive_cycle(input logic v, input logic [XW-1:0] xv, input logic [XW-1:0] yv,
                             input logic rdy, output logic acc, output logic dlv,
                             output logic ov, output logic ir, output logic [W+1:0] obs);
    @(negedge clk);
    in_valid  = v;
    x         = xv;
    y         = yv;
    out_ready = rdy;
    #1;
    ov  = out_valid;
    ir  = in_ready;
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    obs = {sym_err, cout, sum};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({sym_err, cout, sum} !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", {sym_err, cout, sum}); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_before_edge: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL in_ready_after_edge: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [XW-1:0] xv, yv;
    logic acc, dlv, ov, ir;
    logic [W+1:0] obs;
    make_vec(32'd5, 32'd3, 1'b0, xv, yv);
    checks++;
    if (xv[31:0] !== {P, P, G, K}) begin failures++; $display("FAIL model_x_5_3: got %h expected %h", xv[31:0], {P, P, G, K}); end
    drive_cycle(1'b1, xv, yv, 1'b1, acc, dlv, ov, ir, obs);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL basic_accept: got %b expected 1", acc); end
    drive_cycle(1'b0, '0, '0, 1'b1, acc, dlv, ov, ir, obs);
    checks++;
    if (ov !== 1'b0) begin failures++; $display("FAIL basic_latency_early: got %b expected 0", ov); end
    drive_cycle(1'b0, '0, '0, 1'b1, acc, dlv, ov, ir, obs);
    checks++;
    if ({ov, obs} !== {1'b1, 1'b0, 1'b0, 32'd8}) begin
      failures++; $display("FAIL basic_5_plus_3: got valid=%b val=%h expected valid=1 val=%h", ov, obs, {2'b00, 32'd8});
    end
    drive_cycle(1'b0, '0, '0, 1'b1, acc, dlv, ov, ir, obs);
    checks++;
    if (ov !== 1'b0) begin failures++; $display("FAIL basic_single_beat: got %b expected 0", ov); end

    make_vec(32'hFFFF_FFFF, 32'd0, 1'b1, xv, yv);
    drive_cycle(1'b1, xv, yv, 1'b1, acc, dlv, ov, ir, obs);
    drive_cycle(1'b0, '0, '0, 1'b1, acc, dlv, ov, ir, obs);
    drive_cycle(1'b0, '0, '0, 1'b1, acc, dlv, ov, ir, obs);
    checks++;
    if ({ov, obs} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
      failures++; $display("FAIL all_ones_cin: got valid=%b val=%h expected valid=1 val=%h", ov, obs, {2'b01, 32'd0});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [8] = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                             32'd0, 32'hAAAA_AAAA, 32'h7FFF_FFFF, 32'd100};
    logic [W-1:0] vb [8] = '{32'd1, 32'h8000_0000, 32'd1, 32'h1111_1111,
                             32'd0, 32'h5555_5555, 32'h7FFF_FFFF, 32'd200};
    logic         vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W:0]   ve [8] = '{{1'b0, 32'd2}, {1'b1, 32'd0}, {1'b1, 32'd0}, {1'b0, 32'h2345_6789},
                             {1'b0, 32'd1}, {1'b1, 32'd0}, {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'h12C}};
    logic [XW-1:0] xv, yv;
    logic acc, dlv, ov, ir, v;
    logic [W+1:0] obs, e;
    int k = 0, got = 0, first = -1, last = -1;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      xv = '0; yv = '0; v = 1'b0;
      if (k < 8) begin make_vec(va[k], vb[k], vc[k], xv, yv); v = 1'b1; end
      drive_cycle(v, xv, yv, 1'b1, acc, dlv, ov, ir, obs);
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected: got %h expected no output", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL b2b_result%0d: got %h expected %h", got, obs, e); end
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (acc) begin exp_q.push_back({1'b0, ve[k]}); k++; end
    end
    checks++;
    if (got != 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", got); end
    checks++;
    if (last - first != 7) begin failures++; $display("FAIL b2b_consecutive: got span %0d expected 7", last - first); end
  endtask

  task automatic test_stall();
    logic [W-1:0] va [3] = '{32'd10, 32'hFFFF_0000, 32'd3};
    logic [W-1:0] vb [3] = '{32'd20, 32'h0001_0000, 32'd4};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   ve [3] = '{{1'b0, 32'd30}, {1'b1, 32'd0}, {1'b0, 32'd8}};
    logic [XW-1:0] xv, yv;
    logic acc, dlv, ov, ir, v, rdy;
    logic [W+1:0] obs, e;
    int k = 0, got = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      xv = '0; yv = '0; v = 1'b0;
      if (k < 3) begin make_vec(va[k], vb[k], vc[k], xv, yv); v = 1'b1; end
      rdy = (cyc >= 5);
      drive_cycle(v, xv, yv, rdy, acc, dlv, ov, ir, obs);
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (ir !== 1'b0) begin failures++; $display("FAIL stall_in_ready_c%0d: got %b expected 0", cyc, ir); end
        checks++;
        if ({ov, obs} !== {1'b1, 1'b0, ve[0]}) begin
          failures++; $display("FAIL stall_hold_c%0d: got valid=%b val=%h expected valid=1 val=%h", cyc, ov, obs, {1'b0, ve[0]});
        end
      end
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stall_unexpected: got %h expected no output", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL stall_result%0d: got %h expected %h", got, obs, e); end
        end
        got++;
      end
      if (acc) begin exp_q.push_back({1'b0, ve[k]}); k++; end
      if (cyc == 4) begin
        checks++;
        if (k != 2) begin failures++; $display("FAIL stall_accepted: got %0d expected 2", k); end
      end
    end
    checks++;
    if (got != 3) begin failures++; $display("FAIL stall_delivered: got %0d expected 3", got); end
  endtask

  task automatic test_reset_mid();
    logic [XW-1:0] xv, yv;
    logic acc, dlv, ov, ir;
    logic [W+1:0] obs;
    int seen = 0;
    make_vec(32'd7, 32'd9, 1'b0, xv, yv);
    drive_cycle(1'b1, xv, yv, 1'b0, acc, dlv, ov, ir, obs);
    drive_cycle(1'b1, xv, yv, 1'b0, acc, dlv, ov, ir, obs);
    drive_cycle(1'b0, '0, '0, 1'b0, acc, dlv, ov, ir, obs);
    checks++;
    if (ov !== 1'b1) begin failures++; $display("FAIL rstmid_inflight: got %b expected 1", ov); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async_clear: got %b expected 0", out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, acc, dlv, ov, ir, obs);
      if (ov) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rstmid_stale: got %0d outputs expected 0", seen); end
  endtask

`ifdef CLA_SYM_CHECK_EN
  task automatic test_sym_err();
    logic [XW-1:0] xs [3], ys [3];
    logic [W+1:0]  ve [3] = '{{1'b1, 1'b0, 32'd8}, {1'b1, 1'b0, 32'd12}, {1'b0, 1'b0, 32'd8}};
    logic [XW-1:0] xv, yv;
    logic acc, dlv, ov, ir, v;
    logic [W+1:0] obs, e;
    int k = 0, got = 0;
    make_vec(32'd5, 32'd3, 1'b0, xv, yv);
    xs[0] = xv; ys[0] = yv; ys[0][7*8 +: 8] = P;
    xs[1] = xv; ys[1] = yv; xs[1][3*8 +: 8] = 8'h00;
    xs[2] = xv; ys[2] = yv;
    exp_q.delete();
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      v = (k < 3);
      drive_cycle(v, v ? xs[k] : '0, v ? ys[k] : '0, 1'b1, acc, dlv, ov, ir, obs);
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sym_unexpected: got %h expected no output", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL sym_result%0d: got %h expected %h", got, obs, e); end
        end
        got++;
      end
      if (acc) begin exp_q.push_back(ve[k]); k++; end
    end
    checks++;
    if (got != 3) begin failures++; $display("FAIL sym_count: got %0d expected 3", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef CLA_SYM_CHECK_EN
    test_sym_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
